lc3b_write_buffer: RTL and testbench

//  Parametrised eviction/write buffer between the L1 cache and the next level (L2 or physical memory).

---
 rtl/lc3b_types.sv | 12 +
 rtl/lc3b_wb_match.sv | 35 +++
 rtl/lc3b_write_buffer.sv | 134 +++++++++++++
 tb/tb_lc3b_write_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: line address, line data bus, write-buffer drain states.
package lc3b_types;

  localparam int LC3B_LINE_WIDTH  = 128;
  localparam int LC3B_OFFSET_BITS = 4;

  typedef logic [11:0]                lc3b_line_addr;
  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_datbus;

  typedef enum logic {wb_idle, wb_write} lc3b_wb_state;

endpackage

// File: rtl/lc3b_wb_match.sv
// Associative search over the write-buffer entries; the newest valid match
// (scanning backwards from tail) wins.
module lc3b_wb_match #(
  parameter  int DEPTH      = 4,
  parameter  int ADDR_WIDTH = 12,
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                 valid,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
  input  logic [PW-1:0]                    tail,
  input  logic [ADDR_WIDTH-1:0]            probe,
  output logic                             hit,
  output logic [DEPTH-1:0]                 onehot,
  output logic [PW-1:0]                    idx
);

  logic [PW-1:0] slot;

  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    slot   = '0;
    // k = 0 is the entry just behind tail, i.e. the most recently allocated
    for (int k = 0; k < DEPTH; k++) begin
      slot = tail - PW'(k + 1);
      if (!hit && valid[slot] && (addrs[slot] == probe)) begin
        hit          = 1'b1;
        onehot[slot] = 1'b1;
        idx          = slot;
      end
    end
  end

endmodule

// File: rtl/lc3b_write_buffer.sv
// FIFO eviction buffer between L1 and memory, drained one line per pmem handshake.
// Optional WB_COALESCE_EN: pushes that hit a queued (non in-flight) line overwrite it in place.
module lc3b_write_buffer
  import lc3b_types::*;
#(
  parameter int LINE_WIDTH = LC3B_LINE_WIDTH,
  parameter int ADDR_WIDTH = $bits(lc3b_line_addr),
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic [LINE_WIDTH-1:0]        in_data,
  output logic                         pmem_write,
  output logic [ADDR_WIDTH-1:0]        pmem_address,
  output logic [LINE_WIDTH-1:0]        pmem_wdata,
  input  logic                         pmem_resp,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr,
  output logic                         lookup_hit,
  output logic [LINE_WIDTH-1:0]        lookup_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][LINE_WIDTH-1:0] data_q;
  logic [DEPTH-1:0]                 valid_q;
  logic [PW-1:0]                    head_q, tail_q;
  logic [CW-1:0]                    count_q;
  lc3b_wb_state                     state_q;

  logic not_full, push, alloc, pop, coalesce;

  logic             lk_hit;
  logic [DEPTH-1:0] lk_onehot;
  logic [PW-1:0]    lk_idx;
  logic             lk_unused;

  lc3b_wb_match #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lookup (
    .valid  (valid_q),
    .addrs  (addr_q),
    .tail   (tail_q),
    .probe  (lookup_addr),
    .hit    (lk_hit),
    .onehot (lk_onehot),
    .idx    (lk_idx)
  );
  assign lk_unused = ^lk_onehot;

  assign not_full = (count_q != CW'(DEPTH));

`ifdef WB_COALESCE_EN
  logic [DEPTH-1:0] head_oh, co_valid, co_onehot;
  logic [PW-1:0]    co_idx;
  logic             co_hit, co_unused;

  // The in-flight head is masked so pmem_wdata never changes mid-transaction
  assign head_oh  = DEPTH'(1) << head_q;
  assign co_valid = valid_q & ~((state_q == wb_write) ? head_oh : '0);

  lc3b_wb_match #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_coalesce (
    .valid  (co_valid),
    .addrs  (addr_q),
    .tail   (tail_q),
    .probe  (in_addr),
    .hit    (co_hit),
    .onehot (co_onehot),
    .idx    (co_idx)
  );
  assign co_unused = ^co_onehot;
  assign coalesce  = co_hit;
`else
  assign coalesce  = 1'b0;
`endif

  assign in_ready = not_full || coalesce;
  assign push     = in_valid && in_ready;
  assign alloc    = push && !coalesce;
  assign pop      = (state_q == wb_write) && pmem_resp;

  // Payload storage carries no reset; valid_q qualifies every read
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
`ifdef WB_COALESCE_EN
    if (push && coalesce) begin
      data_q[co_idx] <= in_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      state_q <= wb_idle;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);
      case (state_q)
        wb_idle:  if (count_q != '0) state_q <= wb_write;
        wb_write: if (pmem_resp)     state_q <= wb_idle;
        default:                     state_q <= wb_idle;
      endcase
    end
  end

  assign pmem_write   = (state_q == wb_write);
  assign pmem_address = addr_q[head_q];
  assign pmem_wdata   = data_q[head_q];

  assign lookup_hit  = lk_hit;
  assign lookup_data = lk_hit ? data_q[lk_idx] : '0;

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_lc3b_write_buffer.sv
// Directed bench for lc3b_write_buffer (DEPTH=4); expectations follow WB_COALESCE_EN.
module tb_lc3b_write_buffer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [11:0]  in_addr;
  logic [127:0] in_data;
  logic         pmem_write;
  logic [11:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [11:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic [2:0]   count;
  logic         empty;

  int n_checks = 0;
  int n_pass   = 0;

  lc3b_write_buffer #(.LINE_WIDTH(128), .ADDR_WIDTH(12), .DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .count        (count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_data(input logic [11:0] a, input logic [3:0] t);
    return {8{t, a}};
  endfunction

  task automatic push(input logic [11:0] a, input logic [127:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    while (!pmem_write && n < 20) begin
      step();
      n++;
    end
    check(tag, 128'(pmem_write), 128'd1);
  endtask

  task automatic drain_one(input logic [11:0] a, input logic [127:0] d);
    wait_write("drain_wait");
    check("drain_addr", 128'(pmem_address), 128'(a));
    check("drain_data", pmem_wdata, d);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    check("drain_gap", 128'(pmem_write), 128'd0);
  endtask

  task automatic probe(input string tag, input logic [11:0] a, input logic h, input logic [127:0] d);
    lookup_addr = a;
    #1;
    check({tag, "_hit"}, 128'(lookup_hit), 128'(h));
    check({tag, "_data"}, lookup_data, d);
  endtask

  initial begin
    logic [127:0] d_aa;
    reset_n     = 1'b0;
    in_valid    = 1'b1;
    in_addr     = 12'h0A1;
    in_data     = '1;
    pmem_resp   = 1'b0;
    lookup_addr = 12'h0A1;
    d_aa        = {16{8'hAA}};

    // 1: reset with in_valid held high
    repeat (3) step();
    check("rst_count_in_reset", 128'(count), 128'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_empty", 128'(empty), 128'd1);
    check("rst_pmem_write", 128'(pmem_write), 128'd0);
    check("rst_lookup_hit", 128'(lookup_hit), 128'd0);

    // 2: single line, one-cycle latency, stall then response
    push(12'h0A1, d_aa);
    check("t2_count", 128'(count), 128'd1);
    check("t2_write_not_yet", 128'(pmem_write), 128'd0);
    step();
    check("t2_write_up", 128'(pmem_write), 128'd1);
    check("t2_addr", 128'(pmem_address), 128'h0A1);
    probe("t2_probe", 12'h0A1, 1'b1, d_aa);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_write", 128'(pmem_write), 128'd1);
      check("t2_hold_addr", 128'(pmem_address), 128'h0A1);
      check("t2_hold_data", pmem_wdata, d_aa);
    end
    pmem_resp = 1'b1;
    #1;
    check("t2_visible_before_pop", 128'(lookup_hit), 128'd1);
    step();
    pmem_resp = 1'b0;
    check("t2_empty", 128'(empty), 128'd1);
    check("t2_write_down", 128'(pmem_write), 128'd0);
    probe("t2_probe_gone", 12'h0A1, 1'b0, 128'd0);

    // 3: fill to DEPTH, fifth line held off until one pop
    for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), mk_data(12'h100 + 12'(i), 4'h3));
    check("t3_full_count", 128'(count), 128'd4);
    check("t3_full_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b1;
    in_addr  = 12'h104;
    in_data  = mk_data(12'h104, 4'h3);
    step();
    step();
    check("t3_held_count", 128'(count), 128'd4);
    check("t3_held_ready", 128'(in_ready), 128'd0);
    check("t3_head_addr", 128'(pmem_address), 128'h100);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    check("t3_after_pop_count", 128'(count), 128'd3);
    check("t3_after_pop_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("t3_refill_count", 128'(count), 128'd4);
    for (int i = 1; i < 5; i++) drain_one(12'h100 + 12'(i), mk_data(12'h100 + 12'(i), 4'h3));
    check("t3_drained", 128'(empty), 128'd1);

    // 4: duplicate address behind a stalled head
    push(12'h020, mk_data(12'h020, 4'hC));
    push(12'h010, mk_data(12'h010, 4'hA));
    push(12'h010, mk_data(12'h010, 4'hB));
    check("t4_head", 128'(pmem_address), 128'h020);
    probe("t4_probe", 12'h010, 1'b1, mk_data(12'h010, 4'hB));
    probe("t4_probe_head", 12'h020, 1'b1, mk_data(12'h020, 4'hC));
`ifdef WB_COALESCE_EN
    check("t4_count", 128'(count), 128'd2);
    drain_one(12'h020, mk_data(12'h020, 4'hC));
    drain_one(12'h010, mk_data(12'h010, 4'hB));
`else
    check("t4_count", 128'(count), 128'd3);
    drain_one(12'h020, mk_data(12'h020, 4'hC));
    drain_one(12'h010, mk_data(12'h010, 4'hA));
    drain_one(12'h010, mk_data(12'h010, 4'hB));
`endif
    check("t4_drained", 128'(empty), 128'd1);

    // 5: push and pop on the same edge
    push(12'h030, mk_data(12'h030, 4'h5));
    push(12'h031, mk_data(12'h031, 4'h5));
    wait_write("t5_wait");
    check("t5_count_before", 128'(count), 128'd2);
    pmem_resp = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 12'h032;
    in_data   = mk_data(12'h032, 4'h5);
    step();
    pmem_resp = 1'b0;
    in_valid  = 1'b0;
    check("t5_count_after", 128'(count), 128'd2);
    probe("t5_probe_new", 12'h032, 1'b1, mk_data(12'h032, 4'h5));
    probe("t5_probe_popped", 12'h030, 1'b0, 128'd0);
    drain_one(12'h031, mk_data(12'h031, 4'h5));
    drain_one(12'h032, mk_data(12'h032, 4'h5));

    // 6: asynchronous reset in the middle of a write
    push(12'h040, mk_data(12'h040, 4'h6));
    push(12'h041, mk_data(12'h041, 4'h6));
    wait_write("t6_wait");
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_write_dropped", 128'(pmem_write), 128'd0);
    check("t6_count", 128'(count), 128'd0);
    check("t6_empty", 128'(empty), 128'd1);
    probe("t6_miss_040", 12'h040, 1'b0, 128'd0);
    probe("t6_miss_041", 12'h041, 1'b0, 128'd0);
    probe("t6_miss_032", 12'h032, 1'b0, 128'd0);
    step();
    reset_n = 1'b1;
    step();
    check("t6_idle_after", 128'(pmem_write), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
